// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit: FSM state
// encoding and the AddrMode values carried on req_addrmode.
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic ADDRMODE_WORD = 1'b0;
  localparam logic ADDRMODE_BYTE = 1'b1;

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// byte_lane_unit: purely combinational byte-lane helper. Extracts the
// little-endian byte selected by i_lane (zero-extended) for LBU, and builds
// the read-modify-write word for SB by replacing that lane with i_byte.
module byte_lane_unit (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_lane_ext,
  output logic [31:0] o_merged
);

  logic [4:0] w_bit_base;

  assign w_bit_base = {i_lane, 3'b000};

  // Lane extraction and lane replacement for the selected byte.
  always_comb begin
    // NOTE: every output gets a full default before the partial update,
    // otherwise the untouched bits would infer a latch.
    o_lane_ext = 32'h0;
    o_merged   = i_word;
    o_lane_ext[7:0]           = i_word[w_bit_base +: 8];
    o_merged[w_bit_base +: 8] = i_byte;
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store front end to a
// synchronous SRAM with one-cycle read latency. Supports LW/SW (word) and
// LBU/SB (byte); SB is a read-modify-write. Optional feature selected by
// the macro MEM_MISALIGN_CHECK_EN: misaligned word accesses are answered
// with resp_err=1 without touching memory.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_addrmode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_write;
  logic                  r_addrmode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [31:0]           r_merged;
  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_word_store;
  logic [31:0]           w_lane_ext;
  logic [31:0]           w_merged;

  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_word_store = r_write && (r_addrmode == ADDRMODE_WORD);

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_err;

  assign w_misalign = (req_addrmode == ADDRMODE_WORD) && (req_addr[1:0] != 2'b00);
  assign resp_err   = r_err;

  // Error flag is decided at acceptance and held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_misalign;
    end
  end
`else
  assign w_misalign = 1'b0;
  assign resp_err   = 1'b0;
`endif

  assign resp_rdata = r_rdata;
  assign mem_addr   = r_addr[ADDR_WIDTH-1:2];

  byte_lane_unit u_byte_lane (
    .i_word     (mem_rdata),
    .i_lane     (r_addr[1:0]),
    .i_byte     (r_wdata[7:0]),
    .o_lane_ext (w_lane_ext),
    .o_merged   (w_merged)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_misalign ? RESP : ACCESS;
      ACCESS:  w_next = w_word_store ? RESP : WAIT;
      WAIT:    w_next = r_write ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake and SRAM control outputs decoded from the current state.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 32'h0;
    case (r_state)
      IDLE:    req_ready = 1'b1;
      ACCESS: begin
        mem_en = 1'b1;
        if (w_word_store) begin
          mem_we    = 1'b1;
          mem_wdata = r_wdata;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = r_merged;
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture, load data capture and SB merge word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_addrmode <= ADDRMODE_WORD;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_merged   <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_addrmode <= req_addrmode;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            // Stores and errored accesses report zero data.
            r_rdata    <= 32'h0;
          end
        end
        WAIT: begin
          if (r_write) begin
            r_merged <= w_merged;
          end else if (r_addrmode == ADDRMODE_BYTE) begin
            r_rdata <= w_lane_ext;
          end else begin
            r_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural one-cycle
// SRAM model. Expectations follow the MEM_MISALIGN_CHECK_EN setting.
module tb_mem_access_unit;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic          req_addrmode;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  // SRAM model and access counters
  logic [31:0] mem [0:15] = '{default: 32'h0};
  int          n_rd = 0;
  int          n_wr = 0;
  int          n_en = 0;
  logic [AW-3:0] last_wr_addr = '0;
  logic [AW-3:0] last_rd_addr = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      n_en <= n_en + 1;
      if (mem_we) begin
        mem[mem_addr[3:0]] <= mem_wdata;
        n_wr               <= n_wr + 1;
        last_wr_addr       <= mem_addr;
      end else begin
        mem_rdata    <= mem[mem_addr[3:0]];
        n_rd         <= n_rd + 1;
        last_rd_addr <= mem_addr;
      end
    end
  end

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addrmode (req_addrmode),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Present a request at a negedge; returns 1 ns after the acceptance edge.
  task automatic do_req(input logic wr, input logic mode, input logic [31:0] addr,
                        input logic [31:0] wd);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req_valid    = 1'b1;
    req_write    = wr;
    req_addrmode = mode;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Latency 1 means resp_valid is already high right after the acceptance edge.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) break;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic xact(input logic wr, input logic mode, input logic [31:0] addr,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output logic err);
    do_req(wr, mode, addr, wd);
    wait_resp(lat);
    rd  = resp_rdata;
    err = resp_err;
    finish_resp();
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_en, mem_we} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {req_ready, resp_valid, resp_err, mem_en, mem_we});
    end
    checks++;
    if (resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0", resp_rdata);
    end
    checks++;
    if (mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_mem_addr: got %h want 0", mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata);
    end
  endtask

  task automatic test_sw_lw();
    int lat; logic [31:0] rd; logic err; int wr0, rd0;
    wr0 = n_wr; rd0 = n_rd;
    xact(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, err);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++;
    if ((n_wr - wr0) != 1 || (n_rd - rd0) != 0) begin
      errors++; $display("FAIL sw_cycles: got wr=%0d rd=%0d want wr=1 rd=0", n_wr - wr0, n_rd - rd0);
    end
    checks++;
    if (last_wr_addr !== 30'h4) begin errors++; $display("FAIL sw_mem_addr: got %h want 4", last_wr_addr); end
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem_data: got %h want deadbeef", mem[4]); end
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL sw_resp: got rdata=%h err=%b want 0/0", rd, err);
    end
    xact(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, err);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL lw_latency: got %0d want 3", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      errors++; $display("FAIL lw_data: got rdata=%h err=%b want deadbeef/0", rd, err);
    end
  endtask

  task automatic test_sb();
    int lat; logic [31:0] rd; logic err; int wr0, rd0;
    xact(1'b1, 1'b0, 32'h10, 32'h11223344, lat, rd, err);
    wr0 = n_wr; rd0 = n_rd;
    xact(1'b1, 1'b1, 32'h12, 32'h5A5A5AAB, lat, rd, err);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL sb_latency: got %0d want 4", lat); end
    checks++;
    if ((n_wr - wr0) != 1 || (n_rd - rd0) != 1) begin
      errors++; $display("FAIL sb_cycles: got wr=%0d rd=%0d want wr=1 rd=1", n_wr - wr0, n_rd - rd0);
    end
    checks++;
    if (last_rd_addr !== 30'h4 || last_wr_addr !== 30'h4) begin
      errors++; $display("FAIL sb_mem_addr: got rd=%h wr=%h want 4/4", last_rd_addr, last_wr_addr);
    end
    checks++;
    if (mem[4] !== 32'h11AB3344) begin errors++; $display("FAIL sb_merge: got %h want 11ab3344", mem[4]); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h want 0", rd); end
  endtask

  task automatic test_lbu();
    int lat; logic [31:0] rd; logic err;
    xact(1'b1, 1'b0, 32'h10, 32'h80FF0102, lat, rd, err);
    xact(1'b0, 1'b1, 32'h13, 32'h0, lat, rd, err);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL lbu_latency: got %0d want 3", lat); end
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_lane3: got %h want 00000080", rd); end
    xact(1'b0, 1'b1, 32'h11, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h00000001) begin errors++; $display("FAIL lbu_lane1: got %h want 00000001", rd); end
    xact(1'b0, 1'b1, 32'h12, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h000000FF) begin errors++; $display("FAIL lbu_lane2: got %h want 000000ff", rd); end
    xact(1'b0, 1'b1, 32'h10, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h00000002) begin errors++; $display("FAIL lbu_lane0: got %h want 00000002", rd); end
  endtask

  task automatic test_resp_hold();
    int lat; logic [31:0] rd; logic err;
    xact(1'b1, 1'b0, 32'h14, 32'hCAFEF00D, lat, rd, err);
    do_req(1'b0, 1'b0, 32'h14, 32'h0);
    wait_resp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'hCAFEF00D) begin
        errors++;
        $display("FAIL hold_cycle%0d: got valid=%b ready=%b rdata=%h want 1/0/cafef00d",
                 i, resp_valid, req_ready, resp_rdata);
      end
    end
    finish_resp();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: got ready=%b valid=%b want 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid_sb();
    int lat; logic [31:0] rd; logic err; int wr0;
    xact(1'b1, 1'b0, 32'h10, 32'h11223344, lat, rd, err);
    wr0 = n_wr;
    do_req(1'b1, 1'b1, 32'h12, 32'h000000AB);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_en, mem_we} !== 5'b10000 ||
        resp_rdata !== 32'h0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got ctrl=%b rdata=%h addr=%h wdata=%h want 10000/0/0/0",
               {req_ready, resp_valid, resp_err, mem_en, mem_we}, resp_rdata, mem_addr, mem_wdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ((n_wr - wr0) != 0 || mem[4] !== 32'h11223344) begin
      errors++; $display("FAIL midrst_mem: got writes=%0d word=%h want 0/11223344", n_wr - wr0, mem[4]);
    end
    xact(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h11223344) begin errors++; $display("FAIL midrst_readback: got %h want 11223344", rd); end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic err; int en0;
    xact(1'b1, 1'b0, 32'h10, 32'h11223344, lat, rd, err);
    en0 = n_en;
    xact(1'b0, 1'b0, 32'h11, 32'h0, lat, rd, err);
`ifdef MEM_MISALIGN_CHECK_EN
    checks++;
    if (lat != 1 || err !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL misalign_resp: got lat=%0d err=%b rdata=%h want 1/1/0", lat, err, rd);
    end
    checks++;
    if ((n_en - en0) != 0) begin errors++; $display("FAIL misalign_mem_en: got %0d cycles want 0", n_en - en0); end
`else
    checks++;
    if (lat != 3 || err !== 1'b0 || rd !== 32'h11223344) begin
      errors++; $display("FAIL unaligned_lw: got lat=%0d err=%b rdata=%h want 3/0/11223344", lat, err, rd);
    end
    checks++;
    if (last_rd_addr !== 30'h4) begin errors++; $display("FAIL unaligned_addr: got %h want 4", last_rd_addr); end
`endif
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addrmode = 1'b0;
    req_addr     = '0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_sw_lw();
    test_sb();
    test_lbu();
    test_resp_hold();
    test_reset_mid_sb();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
